// File: rtl/three_way_demux_8b_pkg.sv
// Shared types and constants for the 3-way write-back demux.
// Route codes share the mux encoding: {sel2, sel1}.
package three_way_demux_8b_pkg;

  localparam int DATA_W      = 8;
  localparam int NUM_CH      = 3;
  localparam int ERR_CNT_MAX = 255;

  typedef logic [1:0] route_t;

  localparam route_t ROUTE_CH0     = 2'b00;
  localparam route_t ROUTE_CH1     = 2'b01;
  localparam route_t ROUTE_CH2     = 2'b10;
  localparam route_t ROUTE_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    route_t            route;
  } stage_t;

  function automatic route_t decode_route(input logic sel1, input logic sel2);
    return {sel2, sel1};
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One buffered output channel: holds a byte with valid until popped.
module demux_out_slot
  import three_way_demux_8b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              can_accept
);

  // Free now, or freed by the consumer on this same edge.
  assign can_accept = !valid || pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/three_way_demux_8b.sv
// Routes one byte per handshake through a single stage register into
// one of three buffered channels; counts illegal route codes.
module three_way_demux_8b
  import three_way_demux_8b_pkg::*;
#(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel1,
  input  logic              in_sel2,
  output logic              out0_valid,
  output logic              out1_valid,
  output logic              out2_valid,
  input  logic              out0_ready,
  input  logic              out1_ready,
  input  logic              out2_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [DATA_W-1:0] out1_data,
  output logic [DATA_W-1:0] out2_data,
  output logic              err,
  output logic [7:0]        err_cnt
);

  logic                           stage_full;
  stage_t                         stage;
  logic                           accept, drain, can_go, is_illegal;
  logic [NUM_CH-1:0]              ch_load, ch_pop, ch_valid, ch_can_accept, ch_ready;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_data;

  assign ch_ready   = {out2_ready, out1_ready, out0_ready};
  assign ch_pop     = ch_valid & ch_ready;
  assign is_illegal = (stage.route == ROUTE_ILLEGAL);

  always_comb begin
    can_go = 1'b0;
    case (stage.route)
      ROUTE_CH0: can_go = ch_can_accept[0];
      ROUTE_CH1: can_go = ch_can_accept[1];
      ROUTE_CH2: can_go = ch_can_accept[2];
      default:   can_go = 1'b1;
    endcase
  end

  assign drain = stage_full && can_go;
  // Ready also when the stage empties on this edge, giving 1 byte/cycle.
  assign in_ready = !rst && (!stage_full || drain);
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      ch_load[i] = drain && (stage.route == route_t'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_full <= 1'b0;
      stage      <= '0;
    end else if (accept) begin
      stage_full <= 1'b1;
      stage      <= '{data: in_data, route: decode_route(in_sel1, in_sel2)};
    end else if (drain) begin
      stage_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (drain && is_illegal) begin
      err <= 1'b1;
      if (err_cnt != 8'(ERR_CNT_MAX)) err_cnt <= err_cnt + 8'd1;
    end
  end

  demux_out_slot u_slot [NUM_CH-1:0] (
    .clk       (clk),
    .rst       (rst),
    .load      (ch_load),
    .load_data ({NUM_CH{stage.data}}),
    .pop       (ch_pop),
    .valid     (ch_valid),
    .data      (ch_data),
    .can_accept(ch_can_accept)
  );

  assign {out2_valid, out1_valid, out0_valid} = ch_valid;
  assign out0_data = ch_data[0];
  assign out1_data = ch_data[1];
  assign out2_data = ch_data[2];

endmodule

// File: tb/tb_three_way_demux_8b.sv
// Directed bench for three_way_demux_8b with per-channel scoreboard queues.
module tb_three_way_demux_8b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_sel1 = 1'b0, in_sel2 = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out0_valid, out1_valid, out2_valid;
  logic       out0_ready = 1'b0, out1_ready = 1'b0, out2_ready = 1'b0;
  logic [7:0] out0_data, out1_data, out2_data;
  logic       err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$], q1[$], q2[$];

  three_way_demux_8b #(.UUID(0), .NAME("dut")) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel1(in_sel1), .in_sel2(in_sel2),
    .out0_valid(out0_valid), .out1_valid(out1_valid), .out2_valid(out2_valid),
    .out0_ready(out0_ready), .out1_ready(out1_ready), .out2_ready(out2_ready),
    .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer side: any handshake pops the oldest expected byte of that channel.
  always @(negedge clk) begin
    if (!rst) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) chk("ch0_unexpected_byte", 32'(q0.size()), 32'd1);
        else chk("ch0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) chk("ch1_unexpected_byte", 32'(q1.size()), 32'd1);
        else chk("ch1_data", out1_data, q1.pop_front());
      end
      if (out2_valid && out2_ready) begin
        if (q2.size() == 0) chk("ch2_unexpected_byte", 32'(q2.size()), 32'd1);
        else chk("ch2_data", out2_data, q2.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer a byte, wait (bounded) for acceptance, score it; returns at accept edge + 1.
  task automatic push(input logic [7:0] d, input logic s1, input logic s2);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_sel1 = s1; in_sel2 = s2;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", in_ready, 1'b1);
    case ({s2, s1})
      2'b00: q0.push_back(d);
      2'b01: q1.push_back(d);
      2'b10: q2.push_back(d);
      default: ;
    endcase
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_valids", {out2_valid, out1_valid, out0_valid}, 3'b000);
    chk("rst_err", {err, err_cnt}, 9'h0);
    step(2);
    @(negedge clk); rst = 1'b0;
    step(1);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single route, consumers stalled
    push(8'hA5, 1'b0, 1'b0);
    chk("single_lat1_valid", out0_valid, 1'b0);
    step(1);
    chk("single_out0", {out0_valid, out0_data}, {1'b1, 8'hA5});
    chk("single_others_idle", {out2_valid, out1_valid}, 2'b00);
    out0_ready = 1'b1; step(1); out0_ready = 1'b0;
    chk("single_popped", out0_valid, 1'b0);

    // Streaming, all consumers ready
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    chk("stream_rdy0", in_ready, 1'b1);
    push(8'h11, 1'b1, 1'b0);
    chk("stream_rdy1", in_ready, 1'b1);
    push(8'h22, 1'b0, 1'b1);
    chk("stream_ch1", {out1_valid, out1_data}, {1'b1, 8'h11});
    chk("stream_rdy2", in_ready, 1'b1);
    push(8'h33, 1'b0, 1'b0);
    chk("stream_ch2", {out2_valid, out2_data}, {1'b1, 8'h22});
    chk("stream_rdy3", in_ready, 1'b1);
    step(1);
    chk("stream_ch0", {out0_valid, out0_data}, {1'b1, 8'h33});
    step(2);
    chk("stream_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    // Backpressure on ch2
    out2_ready = 1'b0;
    push(8'h01, 1'b0, 1'b1);
    push(8'h02, 1'b0, 1'b1);
    step(1);
    chk("bp_out2_hold", {out2_valid, out2_data}, {1'b1, 8'h01});
    chk("bp_in_ready_low", in_ready, 1'b0);
    out2_ready = 1'b1; step(1); out2_ready = 1'b0;
    chk("bp_out2_next", {out2_valid, out2_data}, {1'b1, 8'h02});
    chk("bp_in_ready_back", in_ready, 1'b1);
    out2_ready = 1'b1; step(1);
    chk("bp_out2_empty", out2_valid, 1'b0);

    // Simultaneous pop and refill on ch0
    out0_ready = 1'b0;
    push(8'h10, 1'b0, 1'b0);
    push(8'h20, 1'b0, 1'b0);
    step(1);
    chk("refill_hold", {out0_valid, out0_data}, {1'b1, 8'h10});
    out0_ready = 1'b1; step(1);
    chk("refill_next", {out0_valid, out0_data}, {1'b1, 8'h20});
    step(1);
    chk("refill_empty", out0_valid, 1'b0);

    // Reset mid-stream: out1 full, stage holding another ch1 byte
    out1_ready = 1'b0;
    push(8'h55, 1'b1, 1'b0);
    push(8'h66, 1'b1, 1'b0);
    step(1);
    chk("pre_rst_state", {out1_valid, out1_data, in_ready}, {1'b1, 8'h55, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valids", {out2_valid, out1_valid, out0_valid}, 3'b000);
    chk("mid_rst_data", {out2_data, out1_data, out0_data}, 24'h0);
    chk("mid_rst_err", {err, in_ready}, 2'b00);
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk); rst = 1'b0;
    out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
    step(1);
    chk("post_mid_rst_ready", in_ready, 1'b1);
    step(3);
    chk("no_ghost", {out2_valid, out1_valid, out0_valid}, 3'b000);

    // Illegal route
    push(8'hFF, 1'b1, 1'b1);
    chk("ill_err_not_yet", err, 1'b0);
    step(1);
    chk("ill_err", {err, err_cnt}, {1'b1, 8'd1});
    chk("ill_no_valid", {out2_valid, out1_valid, out0_valid}, 3'b000);
    for (int i = 0; i < 300; i++) push(8'(i), 1'b1, 1'b1);
    step(2);
    chk("ill_saturate", {err, err_cnt}, {1'b1, 8'd255});
    chk("ill_no_valid_end", {out2_valid, out1_valid, out0_valid}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
